score_bcd_conv: RTL

//  Downstream consumer of the egg collector's score/new_score outputs. Converts the 14-bit

---
 rtl/score_bcd_conv.sv | 133 +++++++++++++
 1 files changed

// File: rtl/score_bcd_conv.sv
// Sequential double-dabble converter: saturated binary score -> packed BCD, one shift per clock.
// Optional session high score tracking is enabled by defining SCORE_HISCORE_EN.
module score_bcd_conv #(
    parameter int SCORE_W = 14,
    parameter int NDIG    = 4,
    parameter int SAT_VAL = 9999
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SCORE_W-1:0]   score,
    input  logic                 new_score,
    output logic                 busy,
    output logic                 bcd_valid,
    output logic [4*NDIG-1:0]    digits,
    output logic [4*NDIG-1:0]    hi_digits,
    output logic                 new_hi
);

    localparam int DIG_W = 4 * NDIG;
    localparam int CNT_W = $clog2(SCORE_W);
    localparam logic [SCORE_W-1:0] SAT_CEIL = SAT_VAL[SCORE_W-1:0];
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SCORE_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state;
    logic [SCORE_W-1:0] bin;
    logic [DIG_W-1:0]   scratch;
    logic [DIG_W-1:0]   scratch_adj;
    logic [CNT_W-1:0]   cnt;
    logic               pending;

    function automatic logic [SCORE_W-1:0] saturate(input logic [SCORE_W-1:0] s);
        if (s > SAT_CEIL)
            return SAT_CEIL;
        return s;
    endfunction

    // Add 3 to every nibble >= 5 so that the following left shift carries correctly into the next digit.
    function automatic logic [DIG_W-1:0] dabble_adjust(input logic [DIG_W-1:0] s);
        logic [DIG_W-1:0] r;
        r = s;
        for (int i = 0; i < NDIG; i++) begin
            if (s[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign scratch_adj = dabble_adjust(scratch);
    assign busy        = (state != IDLE);

`ifdef SCORE_HISCORE_EN
    logic [SCORE_W-1:0] conv_val;
    logic [SCORE_W-1:0] hi;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bin       <= '0;
            scratch   <= '0;
            cnt       <= '0;
            pending   <= 1'b0;
            digits    <= '0;
            bcd_valid <= 1'b0;
`ifdef SCORE_HISCORE_EN
            conv_val  <= '0;
            hi        <= '0;
            hi_digits <= '0;
            new_hi    <= 1'b0;
`endif
        end else begin
            bcd_valid <= 1'b0;
`ifdef SCORE_HISCORE_EN
            new_hi    <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (new_score) begin
                        bin     <= saturate(score);
                        scratch <= '0;
                        cnt     <= '0;
`ifdef SCORE_HISCORE_EN
                        conv_val <= saturate(score);
`endif
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (new_score)
                        pending <= 1'b1;
                    scratch <= {scratch_adj[DIG_W-2:0], bin[SCORE_W-1]};
                    bin     <= {bin[SCORE_W-2:0], 1'b0};
                    cnt     <= cnt + 1'b1;
                    if (cnt == CNT_LAST)
                        state <= DONE;
                end
                DONE: begin
                    digits    <= scratch;
                    bcd_valid <= 1'b1;
`ifdef SCORE_HISCORE_EN
                    if (conv_val > hi) begin
                        hi        <= conv_val;
                        hi_digits <= scratch;
                        new_hi    <= 1'b1;
                    end
`endif
                    // A pulse landing on this very edge is served by the restart, which sees the newest score.
                    if (pending || new_score) begin
                        pending <= 1'b0;
                        bin     <= saturate(score);
                        scratch <= '0;
                        cnt     <= '0;
`ifdef SCORE_HISCORE_EN
                        conv_val <= saturate(score);
`endif
                        state   <= SHIFT;
                    end else begin
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SCORE_HISCORE_EN
    assign hi_digits = '0;
    assign new_hi    = 1'b0;
`endif

endmodule
